lh_message_framer: RTL and testbench
====================================

// Module: lh_message_framer
// PURPOSE
// - Upstream feeder of the light-hash core. Collects a host byte stream into a local buffer and checks
//   every character. It then replays the message as one frame: head 0xFF, body bytes, tail 0x00.
// - Captures the 64-bit digest returned by the hash core and presents it to the host with a sticky
//   valid and explicit error flags.
// PARAMETERS
// - MAX_LEN  32    max body bytes per message; power of two, 2..256.
// - TIMEOUT  64    cycles allowed between tail issue and hash digest_ready; >=2.
// PORTS
// - clk             in   1   rising-edge clock
// - rst_n           in   1   synchronous active-low reset
// - in_byte         in   8   host character
// - in_valid        in   1   in_byte/in_last valid
// - in_last         in   1   qualifies final body byte of message
// - in_ready        out  1   framer accepts host byte this cycle
// - message_byte    out  8   byte to hash core
// - message_valid   out  1   message_byte valid
// - out_ready       in   1   hash side consumes message_byte this cycle
// - digest          in   64  digest from hash core
// - digest_ready    in   1   digest valid (single-cycle pulse from core)
// - hash_out        out  64  captured digest
// - hash_valid      out  1   hash_out valid, held until hash_ack
// - hash_ack        in   1   host consumed hash_out
// - err_char        out  1   invalid character seen (sticky until next accepted byte in IDLE)
// - err_len         out  1   body exceeded MAX_LEN (sticky, same clear)
// - err_timeout     out  1   digest not returned in TIMEOUT cycles (sticky, same clear)
// BEHAVIOUR
// - Reset: all outputs 0, in_ready 0, FSM=IDLE, wr/rd pointers and counters 0. Reset mid-frame aborts
//   it silently; the next cycle after rst_n=1 is IDLE.
// - Valid char: 0x20..0x7E or 0xA1..0xFE. 0xFF and 0x00 are reserved framing bytes, so they are invalid as body.
// - Host handshake: transfer when in_valid&in_ready. message_byte/message_valid stay stable until out_ready.
// - IDLE: in_ready=1. First transfer clears all err_*; then behaves as COLLECT for that byte.
// - COLLECT: in_ready=1; each transfer writes buffer[len], len++.
//   - invalid char -> err_char=1, drop message (len=0), go DRAIN unless in_last (then IDLE).
//   - len would exceed MAX_LEN -> err_len=1, same drop rule.
//   - in_last on valid byte -> HEAD (buffer write still done).
// - DRAIN: in_ready=1, discard bytes until in_last transfer -> IDLE.
// - HEAD: in_ready=0; message_byte=0xFF, message_valid=1; out_ready -> BODY, rd=0.
// - BODY: message_byte=buffer[rd]; each out_ready rd++; after rd==len-1 consumed -> TAIL. One byte/cycle max.
// - TAIL: message_byte=0x00; out_ready -> WAIT, timer=0.
// - WAIT: message_valid=0; timer++ per cycle.
//   - digest_ready -> hash_out<=digest, hash_valid=1 next cycle, -> DONE.
//   - timer==TIMEOUT-1 without digest_ready -> err_timeout=1, -> IDLE. Late digest_ready ignored.
// - DONE: hash_valid held; hash_ack -> hash_valid=0 same edge, -> IDLE. in_ready=0 until then.
// - digest_ready outside WAIT is ignored. hash_ack outside DONE is ignored.
// - Latency: min frame = 3 cycles (head, 1 body, tail) with out_ready tied high; frame length = len+2 cycles.
// - len counter is clog2(MAX_LEN)+1 bits; exactly MAX_LEN bytes is legal, MAX_LEN+1 is err_len.
// TESTING
// - "abc" (0x61,0x62,0x63, last on 0x63), out_ready=1 -> message_byte seq FF,61,62,63,00 on 5 consecutive cycles.
// - Stub returns digest=64'h0123_4567_89AB_CDEF 3 cycles after tail -> hash_out matches, hash_valid held until hash_ack.
// - Byte 0x7F mid-message -> err_char=1, no message_valid until a new message; next valid byte clears err_char.
// - 33 valid bytes with MAX_LEN=32 -> err_len=1, no frame emitted; 32 bytes -> frame of 34 bytes emitted.
// - Tail sent, no digest_ready for TIMEOUT=64 cycles -> err_timeout=1 at cycle 64, FSM IDLE, in_ready=1.
// - out_ready toggled 1/0 during BODY -> message_byte stable while stalled, no byte lost or duplicated.
// - rst_n=0 one cycle during BODY -> all outputs 0; following "x" message frames correctly.

Source files
------------

// File: rtl/lh_message_framer.sv
// Message framer feeding the light-hash core: buffers and validates a host message,
// replays it as FF/body/00, then captures the returned digest with sticky error flags.
module lh_message_framer #(
   parameter int unsigned MAX_LEN = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [7:0]  message_byte,
   output logic        message_valid,
   input  logic        out_ready,
   input  logic [63:0] digest,
   input  logic        digest_ready,
   output logic [63:0] hash_out,
   output logic        hash_valid,
   input  logic        hash_ack,
   output logic        err_char,
   output logic        err_len,
   output logic        err_timeout
);

   localparam int unsigned LW = $clog2(MAX_LEN) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_DRAIN, S_HEAD, S_BODY, S_TAIL, S_WAIT, S_DONE
   } state_t;

   state_t          r_state, w_next;
   logic [7:0]      r_buf [MAX_LEN];
   logic [LW-1:0]   r_len, r_rd;
   logic [TW-1:0]   r_timer;
   logic [63:0]     r_hash_out;
   logic            r_hash_valid, r_err_char, r_err_len, r_err_timeout;

   logic            w_xfer, w_char_ok, w_full, w_last_rd, w_collect, w_wr, w_expire;

   assign w_xfer    = in_valid & in_ready;
   assign w_char_ok = ((in_byte >= 8'h20) && (in_byte <= 8'h7E)) ||
                      ((in_byte >= 8'hA1) && (in_byte <= 8'hFE));
   assign w_full    = (r_len == LW'(MAX_LEN));
   assign w_last_rd = (r_rd == (r_len - LW'(1)));
   assign w_collect = (r_state == S_IDLE) || (r_state == S_COLLECT);
   assign w_wr      = w_xfer & w_collect & w_char_ok & ~w_full;
   assign w_expire  = (r_timer == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      in_ready      = 1'b0;
      message_valid = 1'b0;
      message_byte  = '0;
      case (r_state)
         S_IDLE, S_COLLECT: begin
            in_ready = 1'b1;
            if (w_xfer) begin
               if (!w_char_ok || w_full) w_next = in_last ? S_IDLE : S_DRAIN;
               else                      w_next = in_last ? S_HEAD : S_COLLECT;
            end
         end
         S_DRAIN: begin
            in_ready = 1'b1;
            if (w_xfer && in_last) w_next = S_IDLE;
         end
         S_HEAD: begin
            message_valid = 1'b1;
            message_byte  = 8'hFF;
            if (out_ready) w_next = S_BODY;
         end
         S_BODY: begin
            message_valid = 1'b1;
            message_byte  = r_buf[r_rd[LW-2:0]];
            if (out_ready && w_last_rd) w_next = S_TAIL;
         end
         S_TAIL: begin
            message_valid = 1'b1;
            if (out_ready) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (digest_ready)  w_next = S_DONE;
            else if (w_expire) w_next = S_IDLE;
         end
         S_DONE: begin
            if (hash_ack) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // Handshake outputs are forced low for the whole time reset is asserted.
      if (!rst_n) begin
         in_ready      = 1'b0;
         message_valid = 1'b0;
         message_byte  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_buf[r_len[LW-2:0]] <= in_byte;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_len         <= '0;
         r_rd          <= '0;
         r_timer       <= '0;
         r_hash_out    <= '0;
         r_hash_valid  <= 1'b0;
         r_err_char    <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_COLLECT: begin
               if (w_xfer) begin
                  // First byte of a new message clears old errors; a new error from it wins.
                  if (r_state == S_IDLE) begin
                     r_err_char    <= 1'b0;
                     r_err_len     <= 1'b0;
                     r_err_timeout <= 1'b0;
                  end
                  if (!w_char_ok) begin
                     r_err_char <= 1'b1;
                     r_len      <= '0;
                  end else if (w_full) begin
                     r_err_len <= 1'b1;
                     r_len     <= '0;
                  end else begin
                     r_len <= r_len + LW'(1);
                  end
               end
            end
            S_HEAD: if (out_ready) r_rd <= '0;
            S_BODY: if (out_ready) r_rd <= r_rd + LW'(1);
            S_TAIL: begin
               if (out_ready) begin
                  r_timer <= '0;
                  r_len   <= '0;
               end
            end
            S_WAIT: begin
               r_timer <= r_timer + TW'(1);
               if (digest_ready) begin
                  r_hash_out   <= digest;
                  r_hash_valid <= 1'b1;
               end else if (w_expire) begin
                  r_err_timeout <= 1'b1;
               end
            end
            S_DONE: if (hash_ack) r_hash_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   assign hash_out    = r_hash_out;
   assign hash_valid  = r_hash_valid;
   assign err_char    = r_err_char;
   assign err_len     = r_err_len;
   assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_lh_message_framer.sv
// Directed bench for lh_message_framer: character table plus multi-cycle frame,
// digest, error and reset sequences.
module tb_lh_message_framer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_byte;
   logic        in_valid, in_last, in_ready;
   logic [7:0]  message_byte;
   logic        message_valid, out_ready;
   logic [63:0] digest;
   logic        digest_ready;
   logic [63:0] hash_out;
   logic        hash_valid, hash_ack;
   logic        err_char, err_len, err_timeout;

   int checks = 0;
   int errors = 0;

   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   int         frame_cycles;

   typedef struct {
      logic [7:0] b;
      logic       ok;
   } char_vec_t;

   char_vec_t cv[12];

   lh_message_framer #(.MAX_LEN(32), .TIMEOUT(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .message_byte(message_byte), .message_valid(message_valid), .out_ready(out_ready),
      .digest(digest), .digest_ready(digest_ready),
      .hash_out(hash_out), .hash_valid(hash_valid), .hash_ack(hash_ack),
      .err_char(err_char), .err_len(err_len), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      in_byte  = b;
      in_last  = last;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Consumes one frame up to and including the 0x00 tail; leaves the DUT in WAIT.
   task automatic drain(input bit toggle);
      bit         done = 0;
      bit         stalled = 0;
      logic [7:0] prev = '0;
      got.delete();
      frame_cycles = 0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         if (stalled && message_valid) chk("stall_stable", message_byte, prev);
         out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         #1;
         if (message_valid && out_ready) begin
            got.push_back(message_byte);
            if (message_byte == 8'h00) done = 1;
         end
         stalled = message_valid && !out_ready;
         prev    = message_byte;
         frame_cycles++;
         tick();
      end
      out_ready = 1'b0;
      if (!done) chk("frame_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_frame(input string name);
      chk({name, "_len"}, 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk({name, "_byte"}, 64'(got[i]), 64'(exp_q[i]));
   endtask

   task automatic finish_hash(input logic [63:0] d);
      tick();
      digest       = d;
      digest_ready = 1'b1;
      tick();
      digest_ready = 1'b0;
      chk("hash_valid_set", 64'(hash_valid), 64'd1);
      chk("hash_out", hash_out, d);
      hash_ack = 1'b1;
      tick();
      hash_ack = 1'b0;
      chk("hash_valid_clr", 64'(hash_valid), 64'd0);
   endtask

   initial begin
      cv[0]  = '{8'h41, 1'b1};
      cv[1]  = '{8'h7F, 1'b0};
      cv[2]  = '{8'h20, 1'b1};
      cv[3]  = '{8'h1F, 1'b0};
      cv[4]  = '{8'h7E, 1'b1};
      cv[5]  = '{8'h00, 1'b0};
      cv[6]  = '{8'hA1, 1'b1};
      cv[7]  = '{8'hA0, 1'b0};
      cv[8]  = '{8'hFE, 1'b1};
      cv[9]  = '{8'hFF, 1'b0};
      cv[10] = '{8'h80, 1'b0};
      cv[11] = '{8'h5A, 1'b1};

      rst_n = 1'b0; in_byte = '0; in_valid = 0; in_last = 0; out_ready = 0;
      digest = '0; digest_ready = 0; hash_ack = 0;
      tick(); tick();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_msg_valid", 64'(message_valid), 64'd0);
      chk("rst_hash_valid", 64'(hash_valid), 64'd0);
      chk("rst_errs", {61'd0, err_char, err_len, err_timeout}, 64'd0);
      rst_n = 1'b1;
      #1;
      chk("idle_in_ready", 64'(in_ready), 64'd1);

      // Single-byte messages across the character-class boundaries.
      for (int i = 0; i < 12; i++) begin
         send(cv[i].b, 1'b1);
         chk("char_err", 64'(err_char), 64'(!cv[i].ok));
         chk("char_msg_valid", 64'(message_valid), 64'(cv[i].ok));
         if (cv[i].ok) begin
            drain(1'b0);
            exp_q = '{8'hFF, cv[i].b, 8'h00};
            check_frame("char_frame");
            finish_hash(64'hA5A5_0000_0000_0000 | 64'(i));
         end else begin
            chk("char_in_ready", 64'(in_ready), 64'd1);
         end
      end

      // "abc": frame on five consecutive cycles, digest three cycles after the tail.
      send(8'h61, 0); send(8'h62, 0); send(8'h63, 1);
      chk("abc_head", {55'd0, message_valid, message_byte}, {55'd0, 1'b1, 8'hFF});
      drain(1'b0);
      exp_q = '{8'hFF, 8'h61, 8'h62, 8'h63, 8'h00};
      check_frame("abc");
      chk("abc_cycles", 64'(frame_cycles), 64'd5);
      tick(); tick();
      digest = 64'h0123_4567_89AB_CDEF; digest_ready = 1'b1;
      tick();
      digest_ready = 1'b0;
      chk("abc_hash_valid", 64'(hash_valid), 64'd1);
      chk("abc_hash_out", hash_out, 64'h0123_4567_89AB_CDEF);
      tick(); tick(); tick();
      chk("abc_hash_held", 64'(hash_valid), 64'd1);
      chk("abc_done_in_ready", 64'(in_ready), 64'd0);
      hash_ack = 1'b1;
      tick();
      hash_ack = 1'b0;
      chk("abc_ack", {62'd0, hash_valid, in_ready}, 64'd1);
      digest = 64'hDEAD_BEEF_DEAD_BEEF; digest_ready = 1'b1;
      tick();
      digest_ready = 1'b0;
      chk("stray_digest", hash_out, 64'h0123_4567_89AB_CDEF);

      // 0x7F mid-message: message dropped, draining until in_last.
      send(8'h41, 0); send(8'h7F, 0);
      chk("mid_err_char", 64'(err_char), 64'd1);
      chk("mid_drain_ready", 64'(in_ready), 64'd1);
      send(8'h42, 0); send(8'h43, 1);
      chk("mid_no_frame", 64'(message_valid), 64'd0);
      chk("mid_err_sticky", 64'(err_char), 64'd1);
      send(8'h44, 1);
      chk("mid_err_clear", 64'(err_char), 64'd0);
      drain(1'b0);
      exp_q = '{8'hFF, 8'h44, 8'h00};
      check_frame("mid_next");
      finish_hash(64'h1);

      // 33 bytes overflow; then exactly 32 bytes with a stalling consumer.
      for (int i = 0; i < 33; i++) send(8'(8'h30 + i), i == 32);
      chk("len_err", 64'(err_len), 64'd1);
      chk("len_no_frame", 64'(message_valid), 64'd0);
      chk("len_idle_ready", 64'(in_ready), 64'd1);
      exp_q = '{8'hFF};
      for (int i = 0; i < 32; i++) begin
         send(8'(8'h40 + i), i == 31);
         exp_q.push_back(8'(8'h40 + i));
      end
      exp_q.push_back(8'h00);
      chk("len_err_clear", 64'(err_len), 64'd0);
      drain(1'b1);
      check_frame("len32");
      finish_hash(64'h32);

      // Timeout: no digest for 64 cycles after the tail.
      send(8'h61, 0); send(8'h62, 1);
      drain(1'b0);
      for (int i = 0; i < 63; i++) tick();
      chk("tmo_early", {62'd0, err_timeout, in_ready}, 64'd0);
      tick();
      chk("tmo_err", 64'(err_timeout), 64'd1);
      chk("tmo_idle_ready", 64'(in_ready), 64'd1);
      digest = 64'h5555; digest_ready = 1'b1;
      tick();
      digest_ready = 1'b0;
      chk("tmo_late_digest", 64'(hash_valid), 64'd0);

      // Reset for one cycle during BODY, then a clean "x" message.
      send(8'h70, 0); send(8'h71, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("rb_body", {55'd0, message_valid, message_byte}, {55'd0, 1'b1, 8'h70});
      rst_n = 1'b0;
      tick();
      chk("rb_outputs", {52'd0, in_ready, message_valid, message_byte, hash_valid},
          64'd0);
      chk("rb_errs", {61'd0, err_char, err_len, err_timeout}, 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rb_idle", 64'(in_ready), 64'd1);
      send(8'h78, 1);
      drain(1'b0);
      exp_q = '{8'hFF, 8'h78, 8'h00};
      check_frame("rb_x");
      finish_hash(64'h78);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
